seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one digit per PRESCALE-cycle slot, blanked at slot start.
// Optional decimal-point support is enabled by defining SEG_SCAN_DP_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [5*NUM_DIGITS-1:0] digit_codes,
  input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]   digit_dp,
  output logic                    dp_n,
`endif
  output logic [4:0]              code_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_en_lat;
  logic [4:0]            r_code;
  logic [NUM_DIGITS-1:0] r_anode;
  logic                  r_frame_tick;

  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_slot_wrap;
  logic                  w_latch;
  logic                  w_en_nxt;
  logic                  w_lit_nxt;
  logic [NUM_DIGITS-1:0] w_anode_nxt;

  always_comb begin
    w_slot_wrap = (r_cnt == CNT_MAX);
    w_cnt_nxt   = w_slot_wrap ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    if (w_slot_wrap)
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
    // Latch happens at cnt==BLANK_CYCLES, never on a wrap edge, so r_idx is already the slot's digit.
    w_latch     = (w_cnt_nxt == CNT_BLK);
    w_en_nxt    = w_latch ? digit_en[r_idx] : r_en_lat;
    w_lit_nxt   = (w_cnt_nxt >= CNT_BLK) && w_en_nxt;
    w_anode_nxt = '1;
    if (w_lit_nxt)
      w_anode_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_en_lat     <= 1'b0;
      r_code       <= 5'b00000;
      r_anode      <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_en_lat     <= w_en_nxt;
      r_anode      <= w_anode_nxt;
      r_frame_tick <= w_slot_wrap && (r_idx == IDX_MAX);
      if (w_latch)
        r_code <= digit_codes[5*r_idx +: 5];
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic r_dp_lat;
  logic r_dp_n;
  logic w_dp_nxt;

  always_comb begin
    w_dp_nxt = w_latch ? digit_dp[r_idx] : r_dp_lat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dp_lat <= 1'b0;
      r_dp_n   <= 1'b1;
    end else begin
      r_dp_lat <= w_dp_nxt;
      r_dp_n   <= ~(w_lit_nxt && w_dp_nxt);
    end
  end

  assign dp_n = r_dp_n;
`endif

  assign code_out   = r_code;
  assign anode      = r_anode;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] digit_codes = {5'h0A, 5'h03, 5'h0B, 5'h1F};
  logic [3:0]  digit_en = 4'hF;
  logic [4:0]  code_out;
  logic [3:0]  anode;
  logic        frame_tick;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  digit_dp = 4'b0000;
  logic        dp_n;
`endif

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .digit_codes (digit_codes),
    .digit_en    (digit_en),
`ifdef SEG_SCAN_DP_EN
    .digit_dp    (digit_dp),
    .dp_n        (dp_n),
`endif
    .code_out    (code_out),
    .anode       (anode),
    .frame_tick  (frame_tick)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves reset released just after an edge, so the next step is edge 1.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    checks++;
    if (anode !== 4'b1111) begin
      errors++; $display("FAIL reset_anode got %b want %b", anode, 4'b1111);
    end
    checks++;
    if (code_out !== 5'h00) begin
      errors++; $display("FAIL reset_code got %h want %h", code_out, 5'h00);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got %b want %b", frame_tick, 1'b0);
    end
`ifdef SEG_SCAN_DP_EN
    checks++;
    if (dp_n !== 1'b1) begin
      errors++; $display("FAIL reset_dp got %b want %b", dp_n, 1'b1);
    end
`endif
  endtask

  task automatic check_basic_edge(input int e, input string tag);
    logic [3:0] ea;
    if (e == 1 || e == 8 || e == 9 || e == 16) ea = 4'b1111;
    else if (e >= 2 && e <= 7) ea = 4'b1110;
    else ea = 4'b1101;
    checks++;
    if (anode !== ea) begin
      errors++; $display("FAIL %s_anode e%0d got %b want %b", tag, e, anode, ea);
    end
    if (e >= 2 && e <= 7) begin
      checks++;
      if (code_out !== 5'h1F) begin
        errors++; $display("FAIL %s_code e%0d got %h want %h", tag, e, code_out, 5'h1F);
      end
    end
    if (e >= 10 && e <= 15) begin
      checks++;
      if (code_out !== 5'h0B) begin
        errors++; $display("FAIL %s_code e%0d got %h want %h", tag, e, code_out, 5'h0B);
      end
    end
  endtask

  task automatic test_basic_scan();
    digit_en = 4'hF;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step();
      check_basic_edge(e, "scan");
    end
  endtask

  task automatic test_frame_tick();
    logic exp_t;
    digit_en = 4'hF;
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      step();
      exp_t = (e == 32) || (e == 64);
      checks++;
      if (frame_tick !== exp_t) begin
        errors++; $display("FAIL tick e%0d got %b want %b", e, frame_tick, exp_t);
      end
    end
  endtask

  task automatic test_enable_mask();
    digit_en = 4'b1011;
    do_reset();
    for (int e = 1; e <= 64; e++) begin
      step();
      checks++;
      if (anode[2] !== 1'b1) begin
        errors++; $display("FAIL mask_dark e%0d got %b want %b", e, anode, 4'b1x11);
      end
      if (e == 26) begin
        checks++;
        if (anode !== 4'b0111) begin
          errors++; $display("FAIL mask_d3 got %b want %b", anode, 4'b0111);
        end
      end
      if (e == 32 || e == 64) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++; $display("FAIL mask_tick e%0d got %b want %b", e, frame_tick, 1'b1);
        end
      end
    end
    digit_en = 4'hF;
  endtask

  task automatic test_mid_slot_change();
    digit_en = 4'hF;
    digit_codes = {5'h0A, 5'h03, 5'h0B, 5'h1F};
    do_reset();
    for (int e = 1; e <= 36; e++) begin
      step();
      if (e == 4) digit_codes[4:0] = 5'h05;
      if (e >= 5 && e <= 7) begin
        checks++;
        if (code_out !== 5'h1F) begin
          errors++; $display("FAIL midchg_hold e%0d got %h want %h", e, code_out, 5'h1F);
        end
      end
      if (e == 33) begin
        checks++;
        if (code_out !== 5'h0A) begin
          errors++; $display("FAIL midchg_blank got %h want %h", code_out, 5'h0A);
        end
      end
      if (e >= 34) begin
        checks++;
        if (code_out !== 5'h05 || anode !== 4'b1110) begin
          errors++; $display("FAIL midchg_new e%0d got %h/%b want %h/%b", e, code_out, anode, 5'h05, 4'b1110);
        end
      end
    end
    digit_codes = {5'h0A, 5'h03, 5'h0B, 5'h1F};
  endtask

  task automatic test_reset_mid();
    digit_en = 4'hF;
    do_reset();
    for (int e = 1; e <= 12; e++) step();
    reset = 1'b1;
    step();
    checks++;
    if (anode !== 4'b1111 || code_out !== 5'h00 || frame_tick !== 1'b0) begin
      errors++; $display("FAIL rstmid got %b/%h/%b want %b/%h/%b", anode, code_out, frame_tick, 4'b1111, 5'h00, 1'b0);
    end
    step();
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
      check_basic_edge(e, "rstmid");
    end
  endtask

`ifdef SEG_SCAN_DP_EN
  task automatic test_dp();
    logic exp_dp;
    digit_en = 4'hF;
    digit_dp = 4'b0001;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step();
      exp_dp = !(((e % 32) >= 2) && ((e % 32) <= 7));
      checks++;
      if (dp_n !== exp_dp) begin
        errors++; $display("FAIL dp e%0d got %b want %b", e, dp_n, exp_dp);
      end
    end
    digit_dp = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_frame_tick();
    test_enable_mask();
    test_mid_slot_change();
    test_reset_mid();
`ifdef SEG_SCAN_DP_EN
    test_dp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
